// File: rtl/piano_pkg.sv
// piano_pkg: note encoding shared by the key encoder and the tone generator.
//   NOTE_C..NOTE_B  white-key note codes 0..6
//   NOTES_PER_OCT   semitones per octave (fullnote = octave*12 + note)
//   OCT_W/NOTE_W/FULLNOTE_W  field widths of the note command
package piano_pkg;

  localparam int NOTES_PER_OCT = 12;
  localparam int OCT_W         = 3;
  localparam int NOTE_W        = 4;
  localparam int FULLNOTE_W    = 6;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_C = 4'd0,
    NOTE_D = 4'd1,
    NOTE_E = 4'd2,
    NOTE_F = 4'd3,
    NOTE_G = 4'd4,
    NOTE_A = 4'd5,
    NOTE_B = 4'd6
  } note_e;

  // Registered note command as seen by the voice logic.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic              valid;
    logic              on;
    logic              off;
  } note_evt_t;

  // octave*12 + note using shifts only: octave*8 + octave*4 + note.
  function automatic logic [FULLNOTE_W-1:0] calc_fullnote(
    input logic [OCT_W-1:0]  oct,
    input logic [NOTE_W-1:0] n
  );
    return {oct, 3'b000}
         + FULLNOTE_W'({oct, 2'b00})
         + FULLNOTE_W'(n);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: one raw asynchronous button -> one debounced level.
//   clk, rst   system clock, synchronous active-high reset
//   tick       shared debounce tick (one-cycle pulse from the top-level divider)
//   raw        raw button level, asynchronous to clk
//   stable     debounced level (0 = released after reset)
// A changed level must be seen on TICKS consecutive ticks before it is
// accepted; any cycle where the synced level matches stable restarts the count.
module key_debouncer #(
  parameter int TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (TICKS < 2) ? 1 : $clog2(TICKS + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt_inc == CNT_W'(TICKS)) begin
          stable <= sync_q[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/piano_key_encoder.sv
// piano_key_encoder: raw key/octave buttons -> one debounced note command.
//   clk, rst     system clock, synchronous active-high reset
//   keys         raw white-key levels (1 = pressed), key i -> note code i
//   oct_up/down  raw octave buttons
//   sustain      sustain pedal (only with PIANO_SUSTAIN_EN defined)
//   note         active note code, held while note_valid=0
//   octave       current octave 0..OCT_MAX
//   fullnote     octave*12 + note
//   note_valid   a note is sounding
//   note_on      one-cycle pulse: new note or note changed
//   note_off     one-cycle pulse: note_valid fell
// Optional feature macro: PIANO_SUSTAIN_EN (adds sustain pedal input/hold).
module piano_key_encoder
  import piano_pkg::*;
#(
  parameter int NUM_KEYS       = 7,
  parameter int DEBOUNCE_DIV   = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int OCT_RESET      = 2,
  parameter int OCT_MAX        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic                  oct_up,
  input  logic                  oct_down,
`ifdef PIANO_SUSTAIN_EN
  input  logic                  sustain,
`endif
  output logic [NOTE_W-1:0]     note,
  output logic [OCT_W-1:0]      octave,
  output logic [FULLNOTE_W-1:0] fullnote,
  output logic                  note_valid,
  output logic                  note_on,
  output logic                  note_off
);

  localparam int IDX_UP = NUM_KEYS;
  localparam int IDX_DN = NUM_KEYS + 1;
`ifdef PIANO_SUSTAIN_EN
  localparam int IDX_SUS = NUM_KEYS + 2;
  localparam int N_IN    = NUM_KEYS + 3;
`else
  localparam int N_IN    = NUM_KEYS + 2;
`endif
  localparam int DIV_W = $clog2(DEBOUNCE_DIV);

  // ---------------- tick divider ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- per-input debouncers ----------------
  logic [N_IN-1:0] raw_vec;
  logic [N_IN-1:0] stab_vec;

`ifdef PIANO_SUSTAIN_EN
  assign raw_vec = {sustain, oct_down, oct_up, keys};
`else
  assign raw_vec = {oct_down, oct_up, keys};
`endif

  key_debouncer #(.TICKS(DEBOUNCE_TICKS)) u_db [N_IN-1:0] (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .raw    (raw_vec),
    .stable (stab_vec)
  );

  // ---------------- priority encoder ----------------
  logic [NUM_KEYS-1:0] key_stab;
  logic                any_key;
  logic [NOTE_W-1:0]   enc;

  assign key_stab = stab_vec[NUM_KEYS-1:0];
  assign any_key  = |key_stab;

  // Scan high to low so the lowest pressed index is the last write.
  always_comb begin
    enc = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_stab[i]) enc = NOTE_W'(i);
    end
  end

  // ---------------- octave ----------------
  logic             up_q, dn_q;
  logic             up_rise, dn_rise;
  logic [OCT_W-1:0] oct_q, oct_nxt;

  assign up_rise = stab_vec[IDX_UP] & ~up_q;
  assign dn_rise = stab_vec[IDX_DN] & ~dn_q;

  always_comb begin
    oct_nxt = oct_q;
    if (up_rise && !dn_rise) begin
      if (oct_q != OCT_W'(OCT_MAX)) oct_nxt = oct_q + 1'b1;
    end else if (dn_rise && !up_rise) begin
      if (oct_q != '0) oct_nxt = oct_q - 1'b1;
    end
  end

  // ---------------- note events ----------------
  note_evt_t evt_q, evt_nxt;
  logic      hold;

`ifdef PIANO_SUSTAIN_EN
  // Pedal keeps the last note sounding once all keys are released.
  assign hold = stab_vec[IDX_SUS] & evt_q.valid;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    evt_nxt       = evt_q;
    evt_nxt.on    = 1'b0;
    evt_nxt.off   = 1'b0;
    evt_nxt.valid = any_key | hold;
    if (any_key) begin
      evt_nxt.note = enc;
      evt_nxt.on   = !evt_q.valid || (enc != evt_q.note);
    end
    evt_nxt.off = evt_q.valid && !evt_nxt.valid;
  end

  // ---------------- output registers ----------------
  logic [FULLNOTE_W-1:0] full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      oct_q       <= OCT_W'(OCT_RESET);
      evt_q.note  <= NOTE_C;
      evt_q.valid <= 1'b0;
      evt_q.on    <= 1'b0;
      evt_q.off   <= 1'b0;
      full_q      <= '0;
    end else begin
      up_q   <= stab_vec[IDX_UP];
      dn_q   <= stab_vec[IDX_DN];
      oct_q  <= oct_nxt;
      evt_q  <= evt_nxt;
      full_q <= calc_fullnote(oct_nxt, evt_nxt.note);
    end
  end

  assign note       = evt_q.note;
  assign note_valid = evt_q.valid;
  assign note_on    = evt_q.on;
  assign note_off   = evt_q.off;
  assign octave     = oct_q;
  assign fullnote   = full_q;

endmodule

// File: tb/tb_piano_key_encoder.sv
module tb_piano_key_encoder;
  import piano_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [6:0]            keys;
  logic                  oct_up, oct_down;
`ifdef PIANO_SUSTAIN_EN
  logic                  sustain;
`endif
  logic [NOTE_W-1:0]     note;
  logic [OCT_W-1:0]      octave;
  logic [FULLNOTE_W-1:0] fullnote;
  logic                  note_valid, note_on, note_off;

  int n_cmp = 0;
  int n_mm  = 0;
  int on_cnt = 0, off_cnt = 0;
  int on_b, off_b;

  always #5 clk = ~clk;

  piano_key_encoder #(
    .NUM_KEYS(7), .DEBOUNCE_DIV(4), .DEBOUNCE_TICKS(3),
    .OCT_RESET(2), .OCT_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .keys(keys), .oct_up(oct_up), .oct_down(oct_down),
`ifdef PIANO_SUSTAIN_EN
    .sustain(sustain),
`endif
    .note(note), .octave(octave), .fullnote(fullnote),
    .note_valid(note_valid), .note_on(note_on), .note_off(note_off)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mm++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse counters plus mutual-exclusion check, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      on_cnt  += int'(note_on);
      off_cnt += int'(note_off);
      if (note_on || note_off) chk("on_off_excl", int'(note_on & note_off), 0);
    end
  end

  task automatic mark();
    on_b  = on_cnt;
    off_b = off_cnt;
  endtask

  task automatic press_up();
    oct_up = 1'b1; clks(20);
  endtask

  initial begin
    rst = 1'b1; keys = '0; oct_up = 1'b0; oct_down = 1'b0;
`ifdef PIANO_SUSTAIN_EN
    sustain = 1'b0;
`endif
    clks(3);
    chk("rst_octave",   octave, 2);
    chk("rst_valid",    note_valid, 0);
    chk("rst_fullnote", fullnote, 0);
    chk("rst_note",     note, 0);
    chk("rst_on",       note_on, 0);
    chk("rst_off",      note_off, 0);
    rst = 1'b0;
    clks(5);

    // single key E
    mark();
    keys = 7'b0000100; clks(40);
    chk("e_note",     note, 2);
    chk("e_fullnote", fullnote, 26);
    chk("e_valid",    note_valid, 1);
    chk("e_on_cnt",   on_cnt - on_b, 1);
    chk("e_off_cnt",  off_cnt - off_b, 0);

    // short glitch on G and on D (D would win if accepted)
    mark();
    keys = 7'b0010110; clks(6);
    keys = 7'b0000100; clks(30);
    chk("gl_note",    note, 2);
    chk("gl_valid",   note_valid, 1);
    chk("gl_on_cnt",  on_cnt - on_b, 0);
    chk("gl_off_cnt", off_cnt - off_b, 0);

    // D and G held: lowest index wins
    mark();
    keys = 7'b0010010; clks(40);
    chk("dg_note",     note, 1);
    chk("dg_fullnote", fullnote, 25);
    chk("dg_on_cnt",   on_cnt - on_b, 1);
    keys = 7'b0010000; clks(40);
    chk("g_note",     note, 4);
    chk("g_fullnote", fullnote, 28);
    chk("g_on_cnt",   on_cnt - on_b, 2);
    chk("g_off_cnt",  off_cnt - off_b, 0);

    // octave up x3 with G held: 3, 4, 4
    mark();
    press_up(); chk("oct_up1", octave, 3); oct_up = 1'b0; clks(20);
    press_up(); chk("oct_up2", octave, 4); oct_up = 1'b0; clks(20);
    press_up(); chk("oct_up3", octave, 4); oct_up = 1'b0; clks(20);
    chk("oct_fullnote", fullnote, 52);
    chk("oct_on_cnt",   on_cnt - on_b, 0);
    oct_down = 1'b1; clks(20); oct_down = 1'b0; clks(20);
    chk("oct_dn",          octave, 3);
    chk("oct_dn_fullnote", fullnote, 40);

`ifdef PIANO_SUSTAIN_EN
    sustain = 1'b1; clks(30);
    mark();
    keys = '0; clks(40);
    chk("sus_valid",   note_valid, 1);
    chk("sus_off_cnt", off_cnt - off_b, 0);
    chk("sus_note",    note, 4);
    sustain = 1'b0; clks(40);
    chk("sus_rel_valid",   note_valid, 0);
    chk("sus_rel_off_cnt", off_cnt - off_b, 1);
`else
    mark();
    keys = '0; clks(40);
    chk("rel_valid",   note_valid, 0);
    chk("rel_off_cnt", off_cnt - off_b, 1);
    chk("rel_note",    note, 4);
    chk("rel_on_cnt",  on_cnt - on_b, 0);
`endif

    // reset mid-debounce: pending C press discarded, octave restored
    keys = 7'b0000001; clks(8);
    rst = 1'b1; clks(2);
    keys = '0; rst = 1'b0;
    mark();
    clks(40);
    chk("mid_rst_valid",  note_valid, 0);
    chk("mid_rst_octave", octave, 2);
    chk("mid_rst_on_cnt", on_cnt - on_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mm);
    $finish;
  end

endmodule
